// File: rtl/tmds_channel_encoder.sv
// TMDS 8b/10b encoder for one colour channel.
// Two-stage pipeline: stage 1 registers the inputs and the input popcount,
// stage 2 builds the transition-minimised word and registers the DC-balanced
// symbol together with the running disparity.
module tmds_channel_encoder #(
  parameter int CNT_W = 6
) (
  input  logic                    clkPixel,
  input  logic                    resetn,
  input  logic                    de,
  input  logic [7:0]              din,
  input  logic [1:0]              ctrl,
  output logic [9:0]              q,
  output logic signed [CNT_W-1:0] disparity
);

  localparam logic [9:0] TOKEN_00 = 10'h354;
  localparam logic [9:0] TOKEN_01 = 10'h0AB;
  localparam logic [9:0] TOKEN_10 = 10'h154;
  localparam logic [9:0] TOKEN_11 = 10'h2AB;

  localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);
  localparam logic signed [CNT_W-1:0] D_MAX = CNT_W'(10);

  logic [7:0] din_s1;
  logic       de_s1;
  logic [1:0] ctrl_s1;
  logic [3:0] n1d_s1;

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] q_m;
  logic [3:0] n1;
  logic signed [CNT_W-1:0] diff;
  logic       d_zero, d_pos, d_neg;
  logic       m_bal, m_pos, m_neg;
  logic [9:0] q_data;
  logic signed [CNT_W-1:0] disp_data;

  // Popcount of the incoming byte, captured alongside it in stage 1.
  always_comb begin
    n1d = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n1d = n1d + 4'(din[i]);
    end
  end

  // Stage 1 input register.
  always_ff @(posedge clkPixel or negedge resetn) begin
    if (!resetn) begin
      din_s1  <= '0;
      de_s1   <= 1'b0;
      ctrl_s1 <= '0;
      n1d_s1  <= '0;
    end else begin
      din_s1  <= din;
      de_s1   <= de;
      ctrl_s1 <= ctrl;
      n1d_s1  <= n1d;
    end
  end

  // Transition-minimised word q_m and its ones/zeros balance.
  always_comb begin
    use_xnor = (n1d_s1 > 4'd4) || ((n1d_s1 == 4'd4) && !din_s1[0]);
    q_m      = '0;
    q_m[0]   = din_s1[0];
    for (int unsigned i = 1; i < 8; i++) begin
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ din_s1[i]) : (q_m[i-1] ^ din_s1[i]);
    end
    q_m[8] = ~use_xnor;
    n1 = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n1 = n1 + 4'(q_m[i]);
    end
    diff = CNT_W'(2 * n1) - EIGHT;
  end

  // DC-balance decision: pick inversion of q_m and the next disparity.
  // Sign tests use the sign bit directly so no mixed-signedness compare creeps in.
  always_comb begin
    d_zero = (disparity == '0);
    d_neg  = disparity[CNT_W-1];
    d_pos  = !d_neg && !d_zero;
    m_bal  = (n1 == 4'd4);
    m_pos  = (n1 > 4'd4);
    m_neg  = (n1 < 4'd4);
    if (d_zero || m_bal) begin
      q_data    = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      disp_data = q_m[8] ? (disparity + diff) : (disparity - diff);
    end else if ((d_pos && m_pos) || (d_neg && m_neg)) begin
      q_data    = {1'b1, q_m[8], ~q_m[7:0]};
      disp_data = disparity + (q_m[8] ? TWO : '0) - diff;
    end else begin
      q_data    = {1'b0, q_m[8], q_m[7:0]};
      disp_data = disparity - (q_m[8] ? '0 : TWO) + diff;
    end
  end

  // Output register: data symbol with disparity update, or control token.
  always_ff @(posedge clkPixel or negedge resetn) begin
    if (!resetn) begin
      q         <= TOKEN_00;
      disparity <= '0;
    end else if (de_s1) begin
      q         <= q_data;
      disparity <= disp_data;
    end else begin
      disparity <= '0;
      case (ctrl_s1)
        2'b00:   q <= TOKEN_00;
        2'b01:   q <= TOKEN_01;
        2'b10:   q <= TOKEN_10;
        default: q <= TOKEN_11;
      endcase
    end
  end

  // Running disparity stays within +/-10 for any legal input stream.
  disp_bound: assert property (@(posedge clkPixel) disable iff (!resetn)
    (disparity <= D_MAX) && (disparity >= -D_MAX));

endmodule

// File: doc/tmds_channel_encoder.md
Name: tmds_channel_encoder

Overview:
DVI/HDMI 8b/10b TMDS encoder for one colour channel, directly downstream of the frame synthesizer's RGB24 output and blank/sync signals.
- The serializer instantiates three copies: blue carries {vsync,hsync} as control, green and red carry 2'b00.
- Output is a registered 10-bit symbol per pixel clock with DC-balancing running disparity.
- Pure RTL, no vendor primitives, so it simulates under Icarus.

Parameters:
CNT_W, 6, width of signed running-disparity counter; legal values 5..8.

Ports:
clkPixel  input  1  pixel clock; all state updates on rising edge
resetn  input  1  asynchronous active-low reset
de  input  1  data enable (= ~blank); 1 = encode data, 0 = send control token
din  input  8  pixel byte for this channel
ctrl  input  2  {c1,c0} control bits used when de=0
q  output  10  TMDS symbol; q[0] is transmitted first
disparity  output  CNT_W  current running disparity (two's complement), for verification

Behaviour:
- Reset (resetn=0, async): q=10'h354 (control token 00), disparity=0, all pipeline registers cleared (de_s1=0, ctrl_s1=0).
- Reset deasserted mid-stream: the encoder restarts from the reset state. It does not resume the prior disparity.
- Latency: fixed 2 cycles from inputs to q. Throughput: one symbol per cycle, no stalls, no handshake.
- Stage 1 (registered) captures:
  - din_s1, de_s1, ctrl_s1
  - n1d = popcount(din), 4 bits
- Stage 2 builds q_m[8:0] combinationally from stage-1 registers:
  - use_xnor = (n1d>4) | (n1d==4 & din_s1[0]==0)
  - q_m[0]=din_s1[0]; q_m[i] = q_m[i-1] XOR din_s1[i], inverted when use_xnor (i=1..7)
  - q_m[8] = ~use_xnor
  - n1 = popcount(q_m[7:0]), n0 = 8-n1; diff = n1-n0, signed, even, range -8..+8
- Output register, when de_s1=1 (D = disparity before update):
  - Case A, D==0 or n1==n0:
    - q = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
    - D += q_m[8] ? diff : -diff
  - Case B, (D>0 & n1>n0) or (D<0 & n0>n1):
    - q = {1, q_m[8], ~q_m[7:0]}
    - D = D + 2*q_m[8] - diff
  - Case C, otherwise:
    - q = {0, q_m[8], q_m[7:0]}
    - D = D - 2*(~q_m[8]) + diff
- Output register, when de_s1=0:
  - D := 0
  - q from ctrl_s1: 00→10'h354, 01→10'h0AB, 10→10'h154, 11→10'h2AB
- Arithmetic:
  - All disparity math is signed at CNT_W bits; comparisons are signed.
  - |D| never exceeds 10 for legal input, so no saturation is required.
  - An assertion in simulation flags |D|>10.
- de transitions:
  - Falling de: the first control symbol zeroes D.
  - Rising de: the first data symbol starts from D=0.
  - Each symbol uses its own cycle's de_s1, with no blending across the edge.
- X-safety: din and ctrl are don't-care for the symbol when not selected, but are still registered.

Test Plan:
- Reset: hold resetn=0, toggle inputs → q=10'h354 and disparity=0 throughout. Release with de=0, ctrl=2'b11 → q=10'h2AB exactly 2 cycles later.
- Control tokens: de=0, ctrl cycles 00,01,10,11 → q = 354, 0AB, 154, 2AB (hex), each 2 cycles delayed; disparity stays 0.
- Disparity sequence from reset: de=1, din=8'h00 for 3 cycles → q = 100, 3FF, 100 (hex) with disparity -8, +2, -6.
- XNOR path: fresh from reset, de=1, din=8'hFF → q=10'h200, disparity=-8. Then din=8'h55 → q_m must decode back to 8'h55 via the standard TMDS decoder.
- Blank mid-stream: after the 0x00 sequence (D=-6), de=0 for one cycle then de=1 with din=8'h00 → q = control token then 10'h100, with disparity 0 then -8.
- Random soak: 100k random din/de/ctrl, with a reference decoder in the bench:
  - decoded data equals din delayed by 2
  - |disparity| ≤ 10
  - disparity after every de=1 run matches the bench's recomputed ones-minus-zeros count
